// File: rtl/seq_code_pkg.sv
// Shared definitions for the 3-bit code sequence: code constants,
// monitor FSM state encoding and the code-to-index mapping.
package seq_code_pkg;

  // The eight codes in sequence order, START first.
  localparam logic [2:0] CODE_START = 3'b000;
  localparam logic [2:0] CODE_A     = 3'b011;
  localparam logic [2:0] CODE_B     = 3'b010;
  localparam logic [2:0] CODE_C     = 3'b101;
  localparam logic [2:0] CODE_D     = 3'b001;
  localparam logic [2:0] CODE_E     = 3'b110;
  localparam logic [2:0] CODE_F     = 3'b100;
  localparam logic [2:0] CODE_G     = 3'b111;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  // Position of a code within the 8-code cycle (bijective).
  function automatic logic [2:0] code_to_idx(input logic [2:0] code);
    logic [2:0] idx;
    case (code)
      CODE_START: idx = 3'd0;
      CODE_A:     idx = 3'd1;
      CODE_B:     idx = 3'd2;
      CODE_C:     idx = 3'd3;
      CODE_D:     idx = 3'd4;
      CODE_E:     idx = 3'd5;
      CODE_F:     idx = 3'd6;
      default:    idx = 3'd7;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/code_pos_decode.sv
// Combinational decoder from a sequence code to its cycle position.
// Also flags the START code. Reused by the display stage.
module code_pos_decode
  import seq_code_pkg::*;
(
  input  logic [2:0] code,
  output logic [2:0] idx,
  output logic       is_start
);

  // Pure lookup; no state.
  always_comb begin
    idx      = code_to_idx(code);
    is_start = (code == CODE_START);
  end

endmodule

// File: rtl/code_seq_monitor.sv
// Sequence monitor for the 3-bit state-sequence generator.
// Hunts for START, confirms LOCK_LEN correct successors, then tracks the
// cycle, flagging violations and counting completed periods.
// Optional build macro: SEQ_MON_ERRCNT_EN enables the saturating err_cnt.
module code_seq_monitor
  import seq_code_pkg::*;
#(
  parameter int LOCK_LEN = 7,
  parameter int PCNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        code_in,
  input  logic              code_vld,
  input  logic              clr_err,
  output logic [2:0]        pos,
  output logic              locked,
  output logic              err_pulse,
  output logic              err_flag,
  output logic              wrap_pulse,
  output logic [PCNT_W-1:0] period_cnt,
  output logic [7:0]        err_cnt
);

  localparam logic [3:0]        LOCK_LEN_C = 4'(LOCK_LEN);
  localparam logic [PCNT_W-1:0] PCNT_MAX   = '1;

  // Registered state.
  mon_state_t        r_state;
  logic [2:0]        r_exp_idx;
  logic [3:0]        r_match_cnt;
  logic [2:0]        r_pos;
  logic              r_locked;
  logic              r_err_pulse;
  logic              r_err_flag;
  logic              r_wrap_pulse;
  logic [PCNT_W-1:0] r_period_cnt;

  // Next-state values.
  mon_state_t        w_state_next;
  logic [2:0]        w_exp_idx_next;
  logic [3:0]        w_match_cnt_next;
  logic [2:0]        w_pos_next;
  logic              w_err_pulse_next;
  logic              w_err_flag_next;
  logic              w_wrap_pulse_next;
  logic [PCNT_W-1:0] w_period_cnt_next;

  // Decoded view of the incoming code.
  logic [2:0]        w_idx;
  logic              w_is_start;
  logic              w_match;
  logic [3:0]        w_match_inc;

  code_pos_decode u_decode (
    .code     (code_in),
    .idx      (w_idx),
    .is_start (w_is_start)
  );

  assign w_match     = (w_idx == r_exp_idx);
  assign w_match_inc = r_match_cnt + 4'd1;

  // Next-state and output logic; everything holds unless a code is sampled.
  always_comb begin
    w_state_next      = r_state;
    w_exp_idx_next    = r_exp_idx;
    w_match_cnt_next  = r_match_cnt;
    w_pos_next        = r_pos;
    w_period_cnt_next = r_period_cnt;
    w_err_pulse_next  = 1'b0;
    w_wrap_pulse_next = 1'b0;

    if (code_vld) begin
      w_pos_next = w_idx;
      case (r_state)
        HUNT: begin
          if (w_is_start) begin
            w_state_next     = SYNC;
            w_exp_idx_next   = 3'd1;
            w_match_cnt_next = 4'd0;
          end
        end

        SYNC: begin
          if (w_match) begin
            w_match_cnt_next = w_match_inc;
            w_exp_idx_next   = r_exp_idx + 3'd1;
            if (w_match_inc == LOCK_LEN_C) begin
              w_state_next = LOCKED;
            end
          end else if (w_is_start) begin
            // A fresh START restarts the confirmation run silently.
            w_exp_idx_next   = 3'd1;
            w_match_cnt_next = 4'd0;
          end else begin
            w_state_next = HUNT;
          end
        end

        LOCKED: begin
          if (w_match) begin
            w_exp_idx_next = r_exp_idx + 3'd1;
            if (w_is_start) begin
              // 111 -> 000 closes one full period.
              w_wrap_pulse_next = 1'b1;
              if (r_period_cnt != PCNT_MAX) begin
                w_period_cnt_next = r_period_cnt + 1'b1;
              end
            end
          end else begin
            w_err_pulse_next  = 1'b1;
            w_period_cnt_next = '0;
            if (w_is_start) begin
              // The offending code is itself a START: begin confirming again.
              w_state_next     = SYNC;
              w_exp_idx_next   = 3'd1;
              w_match_cnt_next = 4'd0;
            end else begin
              w_state_next = HUNT;
            end
          end
        end

        default: begin
          w_state_next = HUNT;
        end
      endcase
    end

    // A new violation outranks a simultaneous clear.
    if (w_err_pulse_next) begin
      w_err_flag_next = 1'b1;
    end else if (clr_err) begin
      w_err_flag_next = 1'b0;
    end else begin
      w_err_flag_next = r_err_flag;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= HUNT;
      r_exp_idx    <= 3'd0;
      r_match_cnt  <= 4'd0;
      r_pos        <= 3'd0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_flag   <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_period_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_exp_idx    <= w_exp_idx_next;
      r_match_cnt  <= w_match_cnt_next;
      r_pos        <= w_pos_next;
      r_locked     <= (w_state_next == LOCKED);
      r_err_pulse  <= w_err_pulse_next;
      r_err_flag   <= w_err_flag_next;
      r_wrap_pulse <= w_wrap_pulse_next;
      r_period_cnt <= w_period_cnt_next;
    end
  end

`ifdef SEQ_MON_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Saturating violation counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= 8'd0;
    end else if (w_err_pulse_next && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif

  assign pos        = r_pos;
  assign locked     = r_locked;
  assign err_pulse  = r_err_pulse;
  assign err_flag   = r_err_flag;
  assign wrap_pulse = r_wrap_pulse;
  assign period_cnt = r_period_cnt;

endmodule

// File: tb/tb_code_seq_monitor.sv
// Self-checking bench for code_seq_monitor: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// run-length based reference model.
module tb_code_seq_monitor;

  localparam int LOCK_LEN = 7;
  localparam int PCNT_W   = 8;
  localparam int PMAX     = (1 << PCNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [2:0]        code_in = 3'd0;
  logic              code_vld = 1'b0;
  logic              clr_err = 1'b0;
  logic [2:0]        pos;
  logic              locked;
  logic              err_pulse;
  logic              err_flag;
  logic              wrap_pulse;
  logic [PCNT_W-1:0] period_cnt;
  logic [7:0]        err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  code_seq_monitor #(.LOCK_LEN(LOCK_LEN), .PCNT_W(PCNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_vld   (code_vld),
    .clr_err    (clr_err),
    .pos        (pos),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_flag   (err_flag),
    .wrap_pulse (wrap_pulse),
    .period_cnt (period_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Sequence order of codes, index -> code.
  logic [2:0] seq_code [8] = '{3'b000, 3'b011, 3'b010, 3'b101,
                               3'b001, 3'b110, 3'b100, 3'b111};

  function automatic int idx_of(input logic [2:0] c);
    for (int k = 0; k < 8; k++) if (seq_code[k] == c) return k;
    return 0;
  endfunction

  // ---------------- reference model ----------------
  // run = number of correct successors since the last START, -1 if none.
  bit m_valid = 0;
  int m_pos, m_prev, m_run, m_period, m_errcnt;
  bit m_locked, m_err_pulse, m_wrap, m_err_flag;

  always @(posedge clk) begin
    int  idx;
    bit  succ, viol;
    if (rst) begin
      m_valid = 1; m_pos = 0; m_prev = 0; m_run = -1; m_period = 0;
      m_errcnt = 0; m_locked = 0; m_err_pulse = 0; m_wrap = 0; m_err_flag = 0;
    end else if (m_valid) begin
      m_err_pulse = 0; m_wrap = 0; viol = 0;
      if (code_vld) begin
        idx  = idx_of(code_in);
        succ = (idx == (m_prev + 1) % 8);
        if (m_locked) begin
          if (succ) begin
            if (idx == 0) begin
              m_wrap = 1;
              if (m_period < PMAX) m_period++;
            end
          end else begin
            viol = 1; m_locked = 0; m_period = 0;
            m_run = (idx == 0) ? 0 : -1;
          end
        end else if (m_run >= 0 && succ) begin
          m_run++;
          if (m_run == LOCK_LEN) m_locked = 1;
        end else begin
          m_run = (idx == 0) ? 0 : -1;
        end
        m_prev = idx;
        m_pos  = idx;
      end
      if (viol) begin
        m_err_pulse = 1; m_err_flag = 1;
        if (m_errcnt < 255) m_errcnt++;
      end else if (clr_err) begin
        m_err_flag = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("pos",        32'(pos),        32'(m_pos));
      chk("locked",     32'(locked),     32'(m_locked));
      chk("err_pulse",  32'(err_pulse),  32'(m_err_pulse));
      chk("err_flag",   32'(err_flag),   32'(m_err_flag));
      chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
      chk("period_cnt", 32'(period_cnt), 32'(m_period));
`ifdef SEQ_MON_ERRCNT_EN
      chk("err_cnt",    32'(err_cnt),    32'(m_errcnt));
`else
      chk("err_cnt",    32'(err_cnt),    32'd0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  bit verbose = 1;

  task automatic step(input logic [2:0] c, input logic v, input logic cl, input logic r);
    code_in = c; code_vld = v; clr_err = cl; rst = r;
    @(posedge clk);
    #1;
    if (verbose)
      $display("txn t=%0t rst=%0b vld=%0b code=%03b clr=%0b -> pos=%0d lk=%0b ep=%0b ef=%0b wp=%0b pc=%0d ec=%0d",
               $time, r, v, c, cl, pos, locked, err_pulse, err_flag, wrap_pulse, period_cnt, err_cnt);
  endtask

  task automatic send(input int i);
    step(seq_code[i % 8], 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int g;
    int r;
    logic [2:0] c;

    // Reset for two cycles.
    step(3'b000, 1'b0, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b1);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_pcnt",   32'(period_cnt), 32'd0);
    chk("rst_eflag",  32'(err_flag), 32'd0);

    // Free-running lock: 000 then seven successors.
    for (int i = 0; i < 7; i++) send(i);
    chk("prelock_locked", 32'(locked), 32'd0);
    send(7);
    chk("lock_locked", 32'(locked), 32'd1);
    chk("lock_pos",    32'(pos), 32'd7);

    // First period, then three more.
    send(0);
    chk("wrap1_pulse", 32'(wrap_pulse), 32'd1);
    chk("wrap1_pcnt",  32'(period_cnt), 32'd1);
    for (int i = 1; i <= 24; i++) send(i);
    chk("wrap4_pcnt",  32'(period_cnt), 32'd4);

    // Gap with garbage on code_in.
    for (int i = 0; i < 5; i++) begin
      step(3'b111, 1'b0, 1'b0, 1'b0);
      chk("gap_err",    32'(err_pulse), 32'd0);
      chk("gap_locked", 32'(locked), 32'd1);
    end
    send(1);
    chk("resume_locked", 32'(locked), 32'd1);

    // Violation (101 where 010 expected) coinciding with clr_err.
    step(3'b101, 1'b1, 1'b1, 1'b0);
    chk("viol_pulse",  32'(err_pulse), 32'd1);
    chk("viol_flag",   32'(err_flag), 32'd1);
    chk("viol_locked", 32'(locked), 32'd0);
    chk("viol_pcnt",   32'(period_cnt), 32'd0);
`ifdef SEQ_MON_ERRCNT_EN
    chk("viol_errcnt", 32'(err_cnt), 32'd1);
`endif
    step(3'b000, 1'b0, 1'b1, 1'b0);
    chk("clr_pulse", 32'(err_pulse), 32'd0);
    chk("clr_flag",  32'(err_flag), 32'd0);

    // Relock, then run up to three periods.
    for (int i = 0; i < 8; i++) send(i);
    chk("relock", 32'(locked), 32'd1);
    for (int i = 0; i <= 16; i++) send(i);
    chk("pcnt3", 32'(period_cnt), 32'd3);

    // Reset mid-lock.
    step(3'b011, 1'b1, 1'b0, 1'b1);
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_pcnt",   32'(period_cnt), 32'd0);
    chk("midrst_pos",    32'(pos), 32'd0);
    chk("midrst_eflag",  32'(err_flag), 32'd0);
    for (int i = 1; i < 8; i++) send(i);
    chk("nostart_locked", 32'(locked), 32'd0);
    for (int i = 0; i < 8; i++) send(i);
    chk("restart_locked", 32'(locked), 32'd1);

    // Saturation of period_cnt.
    verbose = 0;
    for (int i = 0; i < 8 * 260; i++) send(i);
    chk("sat_pcnt", 32'(period_cnt), 32'(PMAX));
    send(0);
    chk("sat_wrap",  32'(wrap_pulse), 32'd1);
    chk("sat_hold",  32'(period_cnt), 32'(PMAX));

    // Randomized traffic.
    g = 1;
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        step(3'($urandom), 1'($urandom), 1'b0, 1'b1);
      end else if (r < 25) begin
        step(3'($urandom), 1'b0, ($urandom_range(0, 7) == 0), 1'b0);
      end else if (r < 35) begin
        c = 3'($urandom);
        step(c, 1'b1, ($urandom_range(0, 3) == 0), 1'b0);
        g = (idx_of(c) + 1) % 8;
      end else begin
        step(seq_code[g], 1'b1, ($urandom_range(0, 31) == 0), 1'b0);
        g = (g + 1) % 8;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
